timing_decode: RTL and testbench

TIMING_DECODE -- requirements
Module: timing_decode

---
 rtl/timing_decode.sv | 153 +++++++++++++++
 tb/tb_timing_decode.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/timing_decode.sv
// Instruction timing sequencer and opcode decoder.
// Steps through eight one-hot beats T0..T7 for each instruction. The opcode
// is captured at the end of T2 and decoded during T3..T7. A HALT opcode parks
// the sequencer, and STEP mode returns it to idle after each instruction.
module timing_decode (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       step,
  input  logic [3:0] ir_op,
  output logic       t0,
  output logic       t1,
  output logic       t2,
  output logic       t3,
  output logic       t4,
  output logic       t5,
  output logic       t6,
  output logic       t7,
  output logic       op_ld,
  output logic       op_add,
  output logic       op_sub,
  output logic       op_and,
  output logic       op_or,
  output logic       op_xor,
  output logic       op_shl,
  output logic       op_halt,
  output logic       ill,
  output logic       run,
  output logic       halted,
  output logic [7:0] icnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [3:0] OP_LD   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_SHL  = 4'b0111;
  localparam logic [3:0] OP_HALT = 4'b1111;

  state_t     state;
  state_t     stateNext;
  logic [2:0] beat;
  logic [2:0] beatNext;
  logic [3:0] opr;
  logic [7:0] icntReg;
  logic [7:0] beatVec;
  logic [7:0] decVec;
  logic       illLine;

  // State register: sequencer state, beat position, latched opcode and instruction count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      beat    <= 3'd0;
      opr     <= 4'b0000;
      icntReg <= 8'd0;
    end else begin
      state <= stateNext;
      beat  <= beatNext;
      if (state == S_RUN && beat == 3'd2) begin
        opr <= ir_op;
      end
      if (state == S_RUN && beat == 3'd7) begin
        icntReg <= icntReg + 8'd1;
      end
    end
  end

  // Next-state logic: start only matters when stopped; T7 picks halt, idle or next instruction.
  always_comb begin
    stateNext = state;
    beatNext  = beat;
    case (state)
      S_IDLE, S_HALT: begin
        if (start) begin
          stateNext = S_RUN;
          beatNext  = 3'd0;
        end
      end
      S_RUN: begin
        if (beat == 3'd7) begin
          beatNext = 3'd0;
          if (opr == OP_HALT) begin
            stateNext = S_HALT;
          end else if (step) begin
            stateNext = S_IDLE;
          end
        end else begin
          beatNext = beat + 3'd1;
        end
      end
      default: begin
        stateNext = S_IDLE;
        beatNext  = 3'd0;
      end
    endcase
  end

  // Output logic: beat pulses while running, opcode decode only in the execute beats T3..T7.
  always_comb begin
    beatVec = 8'd0;
    decVec  = 8'd0;
    illLine = 1'b0;
    if (state == S_RUN) begin
      beatVec[beat] = 1'b1;
      if (beat >= 3'd3) begin
        case (opr)
          OP_LD:   decVec[0] = 1'b1;
          OP_ADD:  decVec[1] = 1'b1;
          OP_SUB:  decVec[2] = 1'b1;
          OP_AND:  decVec[3] = 1'b1;
          OP_OR:   decVec[4] = 1'b1;
          OP_XOR:  decVec[5] = 1'b1;
          OP_SHL:  decVec[6] = 1'b1;
          OP_HALT: decVec[7] = 1'b1;
          default: illLine   = 1'b1;
        endcase
      end
    end
  end

  assign t0 = beatVec[0];
  assign t1 = beatVec[1];
  assign t2 = beatVec[2];
  assign t3 = beatVec[3];
  assign t4 = beatVec[4];
  assign t5 = beatVec[5];
  assign t6 = beatVec[6];
  assign t7 = beatVec[7];

  assign op_ld   = decVec[0];
  assign op_add  = decVec[1];
  assign op_sub  = decVec[2];
  assign op_and  = decVec[3];
  assign op_or   = decVec[4];
  assign op_xor  = decVec[5];
  assign op_shl  = decVec[6];
  assign op_halt = decVec[7];

  assign ill    = illLine;
  assign run    = (state == S_RUN);
  assign halted = (state == S_HALT);
  assign icnt   = icntReg;

endmodule

// File: tb/tb_timing_decode.sv
// Self-checking bench for timing_decode: directed scenarios plus random
// traffic, compared every cycle against a behavioural model of the sequencer.
module tb_timing_decode;

  logic       clk;
  logic       rst;
  logic       start;
  logic       step;
  logic [3:0] ir_op;
  logic       t0, t1, t2, t3, t4, t5, t6, t7;
  logic       op_ld, op_add, op_sub, op_and, op_or, op_xor, op_shl, op_halt;
  logic       ill;
  logic       run;
  logic       halted;
  logic [7:0] icnt;

  int checks   = 0;
  int failures = 0;
  bit compareOn = 0;

  // Behavioural model: mode 0 = idle, 1 = running, 2 = halted.
  int mMode = 0;
  int mBeat = 0;
  int mOpr  = 0;
  int mIcnt = 0;

  timing_decode dut (
    .clk(clk), .rst(rst), .start(start), .step(step), .ir_op(ir_op),
    .t0(t0), .t1(t1), .t2(t2), .t3(t3), .t4(t4), .t5(t5), .t6(t6), .t7(t7),
    .op_ld(op_ld), .op_add(op_add), .op_sub(op_sub), .op_and(op_and),
    .op_or(op_or), .op_xor(op_xor), .op_shl(op_shl), .op_halt(op_halt),
    .ill(ill), .run(run), .halted(halted), .icnt(icnt)
  );

  wire [7:0] tVec   = {t7, t6, t5, t4, t3, t2, t1, t0};
  wire [7:0] decVec = {op_halt, op_shl, op_xor, op_or, op_and, op_sub, op_add, op_ld};

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Decode line expected for a given opcode value, ignoring beat gating.
  function automatic logic [7:0] codeToLine(int code);
    if (code >= 1 && code <= 7) return 8'(1 << (code - 1));
    if (code == 15) return 8'h80;
    return 8'h00;
  endfunction

  function automatic logic [7:0] expT();
    return (mMode == 1) ? 8'(1 << mBeat) : 8'h00;
  endfunction

  function automatic logic [7:0] expDec();
    return (mMode == 1 && mBeat >= 3) ? codeToLine(mOpr) : 8'h00;
  endfunction

  function automatic logic expIll();
    return (mMode == 1 && mBeat >= 3 && codeToLine(mOpr) == 8'h00);
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Model update on each rising edge from the inputs held since the previous edge.
  always @(posedge clk) begin
    if (rst) begin
      mMode = 0; mBeat = 0; mOpr = 0; mIcnt = 0;
    end else if (mMode != 1) begin
      if (start) begin
        mMode = 1; mBeat = 0;
      end
    end else begin
      if (mBeat == 2) mOpr = int'(ir_op);
      if (mBeat == 7) begin
        mIcnt = (mIcnt + 1) % 256;
        mBeat = 0;
        if (mOpr == 15) mMode = 2;
        else if (step) mMode = 0;
      end else begin
        mBeat = mBeat + 1;
      end
    end
  end

  // Cycle-by-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (compareOn) begin
      checkOutput("beats", tVec, expT());
      checkOutput("decode", decVec, expDec());
      checkOutput("ill", {7'd0, ill}, {7'd0, expIll()});
      checkOutput("run", {7'd0, run}, {7'd0, mMode == 1});
      checkOutput("halted", {7'd0, halted}, {7'd0, mMode == 2});
      checkOutput("icnt", icnt, 8'(mIcnt));
    end
  end

  // Directed scenarios followed by random traffic.
  initial begin
    rst = 1'b1; start = 1'b0; step = 1'b0; ir_op = 4'd0;
    applyStimulus(2);
    compareOn = 1;
    checkOutput("lit_reset_beats", tVec, 8'h00);
    checkOutput("lit_reset_icnt", icnt, 8'd0);
    rst = 1'b0;
    applyStimulus(1);

    // Free run with ADD
    ir_op = 4'b0010; start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    checkOutput("lit_free_t0", tVec, 8'h01);
    applyStimulus(3);
    checkOutput("lit_free_add_t3", decVec, 8'h02);
    applyStimulus(21);
    checkOutput("lit_free_icnt3", icnt, 8'd3);
    checkOutput("lit_free_t0_again", tVec, 8'h01);

    // Opcode latch: LD held despite IR change at T4, SUB next instruction
    ir_op = 4'b0001;
    applyStimulus(4);
    ir_op = 4'b0011;
    applyStimulus(3);
    checkOutput("lit_latch_ld_t7", decVec, 8'h01);
    applyStimulus(4);
    checkOutput("lit_latch_sub_t3", decVec, 8'h04);
    applyStimulus(2);

    // Reset during T5 of SUB
    rst = 1'b1;
    applyStimulus(1);
    checkOutput("lit_midrst_beats", tVec, 8'h00);
    checkOutput("lit_midrst_decode", decVec, 8'h00);
    checkOutput("lit_midrst_icnt", icnt, 8'd0);
    rst = 1'b0;

    // Start in first cycle after reset, then HALT
    start = 1'b1; ir_op = 4'b1111;
    applyStimulus(1);
    start = 1'b0;
    checkOutput("lit_post_rst_t0", tVec, 8'h01);
    applyStimulus(8);
    checkOutput("lit_halt_halted", {7'd0, halted}, 8'h01);
    checkOutput("lit_halt_beats", tVec, 8'h00);
    start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    checkOutput("lit_restart_halted", {7'd0, halted}, 8'h00);
    applyStimulus(7);
    start = 1'b1;
    applyStimulus(1);
    checkOutput("lit_start_on_halt_edge", {7'd0, halted}, 8'h01);
    start = 1'b0;
    applyStimulus(1);
    checkOutput("lit_still_halted", {7'd0, halted}, 8'h01);

    // Step mode with an illegal opcode
    step = 1'b1; ir_op = 4'b1010; start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    applyStimulus(3);
    checkOutput("lit_ill_t3", {7'd0, ill}, 8'h01);
    checkOutput("lit_ill_nodecode", decVec, 8'h00);
    applyStimulus(5);
    checkOutput("lit_step_idle_run", {7'd0, run}, 8'h00);
    checkOutput("lit_step_icnt", icnt, 8'd3);

    // 256 instructions wrap the count; START during T4 is ignored
    rst = 1'b1; step = 1'b0;
    applyStimulus(1);
    rst = 1'b0; ir_op = 4'b0010; start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    applyStimulus(4);
    start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    checkOutput("lit_start_in_t4", tVec, 8'h20);
    applyStimulus(2048 - 5);
    checkOutput("lit_wrap_icnt", icnt, 8'd0);
    checkOutput("lit_wrap_t0", tVec, 8'h01);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 3) == 0);
      step  = ($urandom_range(0, 5) == 0);
      ir_op = 4'($urandom_range(0, 15));
      applyStimulus(1);
    end

    compareOn = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
